// File: rtl/mips_pkg.sv
// Shared pipeline definitions: operand-mux select codes and the per-stage
// control tag carried through EX/MEM and MEM/WB.
package mips_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_WB    = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_W-1:0] dest;
        logic             regwrite;
        logic             memread;
    } pipe_tag_t;

endpackage

// File: rtl/fwd_select.sv
// Select for one ALU operand mux; EX/MEM beats MEM/WB, a load in EX/MEM is
// never a source, and $0 is never forwarded.
module fwd_select
    import mips_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  pipe_tag_t        exmem,
    input  pipe_tag_t        memwb,
    output logic [1:0]       sel
);

    // A load result is valid in MEM/WB, so its memread bit plays no role here.
    logic memwb_memread_unused;
    assign memwb_memread_unused = memwb.memread;

    always_comb begin
        sel = FWD_RF;
        if (memwb.regwrite && (memwb.dest != REG_ZERO) && (memwb.dest == src)) begin
            sel = FWD_WB;
        end
        if (exmem.regwrite && !exmem.memread &&
            (exmem.dest != REG_ZERO) && (exmem.dest == src)) begin
            sel = FWD_EXMEM;
        end
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// Tracks destination tags through ID/EX, EX/MEM and MEM/WB, drives the two
// ALU operand-mux selects and requests a one-cycle load-use stall.
module forward_hazard_unit
    import mips_pkg::*;
#(
    parameter int REG_ADDR_W = REG_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_en,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall,
    output logic [CNT_W-1:0]      stall_count
);

    logic [REG_ADDR_W-1:0] idex_rs;
    logic [REG_ADDR_W-1:0] idex_rt;
    pipe_tag_t             idex_tag;
    pipe_tag_t             exmem_tag;
    pipe_tag_t             memwb_tag;
    logic                  load_use;

    // The stall bubble clears idex memread, so the request drops after one cycle.
    always_comb begin
        load_use = idex_tag.memread && idex_tag.regwrite && (idex_tag.dest != REG_ZERO) &&
                   ((idex_tag.dest == id_rs) || (id_uses_rt && (idex_tag.dest == id_rt)));
        stall    = id_valid && !flush && load_use;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_rs     <= '0;
            idex_rt     <= '0;
            idex_tag    <= '0;
            exmem_tag   <= '0;
            memwb_tag   <= '0;
            stall_count <= '0;
        end else if (pipe_en) begin
            memwb_tag <= exmem_tag;
            exmem_tag <= idex_tag;
            if (stall || flush || !id_valid) begin
                idex_rs  <= '0;
                idex_rt  <= '0;
                idex_tag <= '0;
            end else begin
                idex_rs           <= id_rs;
                idex_rt           <= id_rt;
                idex_tag.dest     <= id_dest;
                idex_tag.regwrite <= id_regwrite;
                idex_tag.memread  <= id_memread;
            end
            // Saturate rather than wrap so a long run never reads as few stalls.
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

    fwd_select u_fwd_a (
        .src   (idex_rs),
        .exmem (exmem_tag),
        .memwb (memwb_tag),
        .sel   (fwd_a_sel)
    );

    fwd_select u_fwd_b (
        .src   (idex_rt),
        .exmem (exmem_tag),
        .memwb (memwb_tag),
        .sel   (fwd_b_sel)
    );

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed instruction sequences for forward_hazard_unit; expectations are
// queued per cycle and checked by an independent monitor on the falling edge.
module tb_forward_hazard_unit;
    import mips_pkg::*;

    localparam int CNT_W = 16;
    localparam int SAT_W = 4;
    localparam int EXP_W = 5 + CNT_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pipe_en;
    logic             flush;
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic [4:0]       id_dest;
    logic             id_regwrite;
    logic             id_memread;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             stall;
    logic [CNT_W-1:0] stall_count;

    logic             rst_sat_n;
    logic [1:0]       sat_a;
    logic [1:0]       sat_b;
    logic             sat_stall;
    logic [SAT_W-1:0] sat_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [EXP_W-1:0] exp_q[$];
    int               cyc_q[$];
    string            name_q[$];

    forward_hazard_unit #(.REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .pipe_en(pipe_en), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .stall(stall), .stall_count(stall_count)
    );

    // Small counter instance fed a self-dependent load (lw $2,0($2)) every cycle.
    forward_hazard_unit #(.REG_ADDR_W(5), .CNT_W(SAT_W)) u_sat (
        .clk(clk), .rst_n(rst_sat_n), .pipe_en(1'b1), .flush(1'b0), .id_valid(1'b1),
        .id_rs(5'd2), .id_rt(5'd2), .id_uses_rt(1'b0), .id_dest(5'd2),
        .id_regwrite(1'b1), .id_memread(1'b1), .fwd_a_sel(sat_a),
        .fwd_b_sel(sat_b), .stall(sat_stall), .stall_count(sat_count)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic ut, input logic [4:0] d, input logic rw, input logic mr);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_uses_rt  = ut;
        id_dest     = d;
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic r_type(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        drive(1'b1, rs, rt, 1'b1, rd, 1'b1, 1'b0);
    endtask

    task automatic lw(input logic [4:0] rt, input logic [4:0] rs);
        drive(1'b1, rs, rt, 1'b0, rt, 1'b1, 1'b1);
    endtask

    task automatic sw(input logic [4:0] rt, input logic [4:0] rs);
        drive(1'b1, rs, rt, 1'b1, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    task automatic expect_out(input string nm, input logic [1:0] a, input logic [1:0] b,
                              input logic st, input logic [CNT_W-1:0] cnt);
        exp_q.push_back({a, b, st, cnt});
        cyc_q.push_back(cyc);
        name_q.push_back(nm);
    endtask

    task automatic sat_check(input string nm, input logic [1:0] a, input logic [1:0] b,
                             input logic st, input logic [SAT_W-1:0] cnt);
        total++;
        if ({sat_a, sat_b, sat_stall, sat_count} !== {a, b, st, cnt}) begin
            bad++;
            $display("FAIL %s: got a=%b b=%b stall=%b count=%0d, want a=%b b=%b stall=%b count=%0d",
                     nm, sat_a, sat_b, sat_stall, sat_count, a, b, st, cnt);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [EXP_W-1:0] act;
        logic [EXP_W-1:0] exp_v;
        string            nm;
        int               c;
        act = {fwd_a_sel, fwd_b_sel, stall, stall_count};
        while (exp_q.size() > 0 && cyc_q[0] <= cyc) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            c     = cyc_q.pop_front();
            total++;
            if (c != cyc) begin
                bad++;
                $display("FAIL %s: expectation from cycle %0d checked at cycle %0d", nm, c, cyc);
            end else if (act !== exp_v) begin
                bad++;
                $display("FAIL %s: got a=%b b=%b stall=%b count=%0d, want a=%b b=%b stall=%b count=%0d",
                         nm, act[EXP_W-1 -: 2], act[EXP_W-3 -: 2], act[CNT_W], act[CNT_W-1:0],
                         exp_v[EXP_W-1 -: 2], exp_v[EXP_W-3 -: 2], exp_v[CNT_W], exp_v[CNT_W-1:0]);
            end
        end
        // A load in EX/MEM must never feed the ALU, nor sit under its own consumer.
        if (rst_n && dut.exmem_tag.memread && dut.exmem_tag.regwrite && dut.exmem_tag.dest != 5'd0) begin
            total++;
            if (fwd_a_sel == FWD_EXMEM || fwd_b_sel == FWD_EXMEM ||
                dut.exmem_tag.dest == dut.idex_rs) begin
                bad++;
                $display("FAIL load_src: a=%b b=%b exmem_dest=%0d idex_rs=%0d",
                         fwd_a_sel, fwd_b_sel, dut.exmem_tag.dest, dut.idex_rs);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        rst_sat_n = 1'b0;
        pipe_en   = 1'b1;
        flush     = 1'b0;
        nop();

        // reset with random inputs
        for (int i = 0; i < 2; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            pipe_en = 1'($urandom_range(0, 1));
            flush   = 1'($urandom_range(0, 1));
            if (i == 1) expect_out("rst_hold", FWD_RF, FWD_RF, 1'b0, 16'd0);
            tick();
        end
        rst_n   = 1'b1;
        pipe_en = 1'b1;
        flush   = 1'b0;
        nop();
        expect_out("rst_out", FWD_RF, FWD_RF, 1'b0, 16'd0);
        tick();
        drain();

        // add $3,$1,$2 ; sub $4,$3,$5
        r_type(5'd3, 5'd1, 5'd2); tick();
        r_type(5'd4, 5'd3, 5'd5); expect_out("exmem_pre", FWD_RF, FWD_RF, 1'b0, 16'd0); tick();
        nop(); expect_out("exmem_a", FWD_EXMEM, FWD_RF, 1'b0, 16'd0); tick();
        drain();

        // add $3 ; nop ; or $6,$7,$3
        r_type(5'd3, 5'd1, 5'd2); tick();
        nop(); tick();
        r_type(5'd6, 5'd7, 5'd3); tick();
        nop(); expect_out("memwb_b", FWD_RF, FWD_WB, 1'b0, 16'd0); tick();
        drain();

        // add $3 ; add $3 ; and $8,$3,$3
        r_type(5'd3, 5'd1, 5'd2); tick();
        r_type(5'd3, 5'd4, 5'd5); tick();
        r_type(5'd8, 5'd3, 5'd3); tick();
        nop(); expect_out("priority", FWD_EXMEM, FWD_EXMEM, 1'b0, 16'd0); tick();
        drain();

        // lw $2,0($1) ; add $4,$2,$5
        lw(5'd2, 5'd1); tick();
        r_type(5'd4, 5'd2, 5'd5); expect_out("lu_stall", FWD_RF, FWD_RF, 1'b1, 16'd0); tick();
        expect_out("lu_release", FWD_RF, FWD_RF, 1'b0, 16'd1); tick();
        nop(); expect_out("lu_fwd", FWD_WB, FWD_RF, 1'b0, 16'd1); tick();
        drain();

        // lw $2,0($1) ; sw $2,0($3)
        lw(5'd2, 5'd1); tick();
        sw(5'd2, 5'd3); expect_out("sw_stall", FWD_RF, FWD_RF, 1'b1, 16'd1); tick();
        expect_out("sw_release", FWD_RF, FWD_RF, 1'b0, 16'd2); tick();
        nop(); expect_out("sw_fwd", FWD_RF, FWD_WB, 1'b0, 16'd2); tick();
        drain();

        // lw $2,0($1) ; lw $2,0($6): rt is a destination, not a source
        lw(5'd2, 5'd1); tick();
        lw(5'd2, 5'd6); expect_out("no_rt_stall", FWD_RF, FWD_RF, 1'b0, 16'd2); tick();
        nop(); expect_out("load_not_src", FWD_RF, FWD_RF, 1'b0, 16'd2); tick();
        drain();

        // add $0,$1,$2 ; sub $4,$0,$0
        r_type(5'd0, 5'd1, 5'd2); tick();
        r_type(5'd4, 5'd0, 5'd0); tick();
        nop(); expect_out("zero_exmem", FWD_RF, FWD_RF, 1'b0, 16'd2); tick();
        expect_out("zero_memwb", FWD_RF, FWD_RF, 1'b0, 16'd2); tick();
        drain();

        // lw $0 ; add $4,$0,$5
        lw(5'd0, 5'd1); tick();
        r_type(5'd4, 5'd0, 5'd5); expect_out("zero_no_stall", FWD_RF, FWD_RF, 1'b0, 16'd2); tick();
        drain();

        // lw $2 in EX, flushed consumer in ID, then or $7,$4,$4
        lw(5'd2, 5'd1); tick();
        r_type(5'd4, 5'd2, 5'd5); flush = 1'b1;
        expect_out("flush_no_stall", FWD_RF, FWD_RF, 1'b0, 16'd2); tick();
        flush = 1'b0;
        r_type(5'd7, 5'd4, 5'd4); expect_out("flush_next", FWD_RF, FWD_RF, 1'b0, 16'd2); tick();
        nop(); expect_out("flush_bubble", FWD_RF, FWD_RF, 1'b0, 16'd2); tick();
        drain();

        // pipe_en low for three edges during a stall
        lw(5'd2, 5'd1); tick();
        r_type(5'd4, 5'd2, 5'd5); pipe_en = 1'b0;
        expect_out("hold_0", FWD_RF, FWD_RF, 1'b1, 16'd2); tick();
        expect_out("hold_1", FWD_RF, FWD_RF, 1'b1, 16'd2); tick();
        expect_out("hold_2", FWD_RF, FWD_RF, 1'b1, 16'd2); tick();
        pipe_en = 1'b1;
        expect_out("hold_3", FWD_RF, FWD_RF, 1'b1, 16'd2); tick();
        expect_out("hold_release", FWD_RF, FWD_RF, 1'b0, 16'd3); tick();
        nop(); expect_out("hold_fwd", FWD_WB, FWD_RF, 1'b0, 16'd3); tick();
        drain();

        // saturation: stall on every odd cycle k, count = k/2 until all-ones
        rst_sat_n = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            #3;
            if (k == 10) sat_check("sat_k10", FWD_RF, FWD_RF, 1'b0, 4'd5);
            if (k == 29) sat_check("sat_k29", FWD_WB, FWD_WB, 1'b1, 4'd14);
            if (k == 31) sat_check("sat_k31", FWD_WB, FWD_WB, 1'b1, 4'hF);
            if (k == 33) sat_check("sat_k33", FWD_WB, FWD_WB, 1'b1, 4'hF);
            if (k == 40) sat_check("sat_k40", FWD_RF, FWD_RF, 1'b0, 4'hF);
            tick();
        end

        tick();
        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: %0d expectations unchecked, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
